// File: rtl/i2c_txn_sequencer.sv
// Transaction-level I2C master: sequences START / address / register / data / STOP
// steps on a bit/byte PHY, streaming write bytes in and read bytes out.
module i2c_txn_sequencer #(
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int TO_W           = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic       cmd_read,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [3:0] cmd_len,
    output logic       busy,
    output logic       done,
    output logic       err_nack,
    output logic       err_timeout,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       phy_start_req,
    output logic       phy_stop_req,
    output logic       phy_write_req,
    output logic       phy_read_req,
    output logic       phy_master_ack,
    output logic [7:0] phy_data_out,
    input  logic       phy_ready,
    input  logic       phy_slave_ack,
    input  logic [7:0] phy_data_in
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_START  = 4'd1;
    localparam logic [3:0] S_ADDR_W = 4'd2;
    localparam logic [3:0] S_REG    = 4'd3;
    localparam logic [3:0] S_RSTART = 4'd4;
    localparam logic [3:0] S_ADDR_R = 4'd5;
    localparam logic [3:0] S_WDATA  = 4'd6;
    localparam logic [3:0] S_RDATA  = 4'd7;
    localparam logic [3:0] S_STOP   = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;

    logic [3:0]      state_q, state_d;
    logic            issued_q, issued_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rd_q, rd_d;
    logic [6:0]      dev_q, dev_d;
    logic [7:0]      reg_q, reg_d;
    logic [7:0]      data_q, data_d;
    logic            err_nack_q, err_nack_d;
    logic            err_to_q, err_to_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;

    logic            is_start, is_write, is_read, is_stop, req_cycle;
    logic [7:0]      step_byte;
    logic [TO_W-1:0] to_inc;

    always_comb begin
        is_start  = (state_q == S_START) || (state_q == S_RSTART);
        is_write  = (state_q == S_ADDR_W) || (state_q == S_REG) ||
                    (state_q == S_ADDR_R) || (state_q == S_WDATA);
        is_read   = (state_q == S_RDATA);
        is_stop   = (state_q == S_STOP);
        // A write-data step only fires once the host has a byte ready.
        req_cycle = !issued_q && (is_start || is_write || is_read || is_stop) &&
                    ((state_q != S_WDATA) || tx_valid);
        case (state_q)
            S_ADDR_W: step_byte = {dev_q, 1'b0};
            S_REG:    step_byte = reg_q;
            S_ADDR_R: step_byte = {dev_q, 1'b1};
            S_WDATA:  step_byte = tx_data;
            default:  step_byte = data_q;
        endcase
        to_inc = to_cnt_q + 1'b1;
    end

    assign phy_start_req  = req_cycle && is_start;
    assign phy_write_req  = req_cycle && is_write;
    assign phy_read_req   = req_cycle && is_read;
    assign phy_stop_req   = req_cycle && is_stop;
    assign tx_ready       = req_cycle && (state_q == S_WDATA);
    assign phy_data_out   = req_cycle ? step_byte : data_q;
    assign phy_master_ack = is_read && (cnt_q != 4'd0);
    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign err_nack       = err_nack_q;
    assign err_timeout    = err_to_q;
    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        to_cnt_d   = to_cnt_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        data_d     = data_q;
        err_nack_d = err_nack_q;
        err_to_d   = err_to_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rd_d       = cmd_read;
                    dev_d      = cmd_dev;
                    reg_d      = cmd_reg;
                    cnt_d      = cmd_len;
                    err_nack_d = 1'b0;
                    err_to_d   = 1'b0;
                    issued_d   = 1'b0;
                    state_d    = S_START;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (!issued_q) begin
                    if (req_cycle) begin
                        issued_d = 1'b1;
                        to_cnt_d = '0;
                        data_d   = step_byte;
                    end
                end else if (phy_ready) begin
                    issued_d = 1'b0;
                    to_cnt_d = '0;
                    case (state_q)
                        S_START:  state_d = S_ADDR_W;
                        S_RSTART: state_d = S_ADDR_R;
                        S_ADDR_W: state_d = phy_slave_ack ? S_REG : S_STOP;
                        S_REG:    state_d = !phy_slave_ack ? S_STOP : (rd_q ? S_RSTART : S_WDATA);
                        S_ADDR_R: state_d = phy_slave_ack ? S_RDATA : S_STOP;
                        S_WDATA: begin
                            if (!phy_slave_ack || cnt_q == 4'd0) state_d = S_STOP;
                            else cnt_d = cnt_q - 4'd1;
                        end
                        S_RDATA: begin
                            rx_data_d  = phy_data_in;
                            rx_valid_d = 1'b1;
                            if (cnt_q == 4'd0) state_d = S_STOP;
                            else cnt_d = cnt_q - 4'd1;
                        end
                        default:  state_d = S_DONE;
                    endcase
                    if (!phy_slave_ack && is_write) err_nack_d = 1'b1;
                end else begin
                    to_cnt_d = to_inc;
                    // A silent PHY cannot be trusted to run STOP either, so finish directly.
                    if (to_inc == TO_W'(TIMEOUT_CYCLES)) begin
                        err_to_d = 1'b1;
                        issued_d = 1'b0;
                        state_d  = S_DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            issued_q   <= 1'b0;
            to_cnt_q   <= '0;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            dev_q      <= '0;
            reg_q      <= '0;
            data_q     <= '0;
            err_nack_q <= 1'b0;
            err_to_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            to_cnt_q   <= to_cnt_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            err_nack_q <= err_nack_d;
            err_to_q   <= err_to_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: a PHY/slave model logs bus events, and a
// transaction-level model predicts the event list, data and error flags.
module tb_i2c_txn_sequencer;
    localparam int TO       = 100;
    localparam int EV_START = 32'h100;
    localparam int EV_STOP  = 32'h200;
    localparam int EV_WR    = 32'h300;
    localparam int EV_RD    = 32'h400;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_read = 1'b0;
    logic [6:0] cmd_dev = '0;
    logic [7:0] cmd_reg = '0;
    logic [3:0] cmd_len = '0;
    logic       busy, done, err_nack, err_timeout, tx_ready, rx_valid;
    logic [7:0] tx_data = '0, rx_data;
    logic       tx_valid = 1'b0;
    logic       phy_start_req, phy_stop_req, phy_write_req, phy_read_req, phy_master_ack;
    logic [7:0] phy_data_out;
    logic       phy_ready = 1'b0, phy_slave_ack = 1'b0;
    logic [7:0] phy_data_in = '0;

    i2c_txn_sequencer #(.TIMEOUT_CYCLES(TO), .TO_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_read(cmd_read),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_len(cmd_len), .busy(busy), .done(done),
        .err_nack(err_nack), .err_timeout(err_timeout), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .phy_start_req(phy_start_req), .phy_stop_req(phy_stop_req),
        .phy_write_req(phy_write_req), .phy_read_req(phy_read_req),
        .phy_master_ack(phy_master_ack), .phy_data_out(phy_data_out), .phy_ready(phy_ready),
        .phy_slave_ack(phy_slave_ack), .phy_data_in(phy_data_in)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int ev_log[$], exp_q[$], tx_src[$], tx_q[$], rx_src[$], rx_got[$], exp_rx[$];
    int exp_txr;
    bit exp_nack;
    int nack_idx = -1, wr_cnt = 0, rd_cnt = 0;
    bit phy_mute = 0, pend = 0;
    int pend_cnt = 0;
    logic pend_ack = 1'b0;
    logic [7:0] pend_data = '0;
    int cyc = 0, txr_cnt = 0, done_cnt = 0, busy_drop = 0, req_cyc = 0, done_cyc = 0;
    bit in_txn = 0, done_busy = 0, done_nack = 0, done_to = 0;

    // PHY + slave model: drive on the falling edge, observe 2 ns later.
    always @(negedge clk) begin
        cyc++;
        phy_ready = 1'b0;
        if (!rst_n) pend = 0;
        else if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                phy_ready = 1'b1; phy_slave_ack = pend_ack; phy_data_in = pend_data; pend = 0;
            end
        end
        tx_valid = (tx_q.size() > 0) && ($urandom_range(0, 2) != 0);
        tx_data  = (tx_q.size() > 0) ? 8'(tx_q[0]) : 8'h00;
        #2;
        if (rst_n) begin
            if (phy_start_req || phy_stop_req || phy_write_req || phy_read_req) begin
                pend = !phy_mute; pend_cnt = $urandom_range(1, 3);
                pend_ack = 1'b1; pend_data = 8'($urandom);
            end
            if (phy_start_req) begin ev_log.push_back(EV_START); req_cyc = cyc; end
            if (phy_stop_req) ev_log.push_back(EV_STOP);
            if (phy_write_req) begin
                ev_log.push_back(EV_WR | int'(phy_data_out));
                pend_ack = (wr_cnt != nack_idx); wr_cnt++;
            end
            if (phy_read_req) begin
                ev_log.push_back(EV_RD | int'(phy_master_ack));
                pend_data = (rd_cnt < rx_src.size()) ? 8'(rx_src[rd_cnt]) : 8'h00; rd_cnt++;
            end
            if (tx_ready) begin txr_cnt++; if (tx_q.size() > 0) void'(tx_q.pop_front()); end
            if (rx_valid) rx_got.push_back(int'(rx_data));
            if (done) begin
                done_cnt++; done_cyc = cyc; done_busy = busy;
                done_nack = err_nack; done_to = err_timeout; in_txn = 0;
            end
            if (in_txn && !busy && !done) busy_drop++;
        end
    end

    function automatic int first_diff(int a[$], int b[$]);
        int n = (a.size() > b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++)
            if (i >= a.size() || i >= b.size() || a[i] != b[i]) return i;
        return -1;
    endfunction

    // Transaction-level prediction: which bytes go on the bus and where a NACK cuts it short.
    task automatic build_model(bit rd, logic [6:0] dev, logic [7:0] rg, int len, int nk);
        bit ok;
        exp_q.delete(); exp_rx.delete(); exp_txr = 0;
        exp_q.push_back(EV_START);
        exp_q.push_back(EV_WR | int'({dev, 1'b0}));
        ok = (nk != 0);
        if (ok) begin exp_q.push_back(EV_WR | int'(rg)); ok = (nk != 1); end
        if (ok && rd) begin
            exp_q.push_back(EV_START);
            exp_q.push_back(EV_WR | int'({dev, 1'b1}));
            ok = (nk != 2);
        end
        for (int i = 0; ok && i <= len; i++) begin
            if (rd) begin
                exp_q.push_back(EV_RD | ((i < len) ? 1 : 0));
                exp_rx.push_back(rx_src[i]);
            end else begin
                exp_q.push_back(EV_WR | tx_src[i]);
                exp_txr++;
                ok = (nk != i + 2);
            end
        end
        exp_q.push_back(EV_STOP);
        exp_nack = !ok;
    endtask

    task automatic fill_random();
        tx_src.delete(); rx_src.delete();
        for (int i = 0; i < 16; i++) begin
            tx_src.push_back($urandom_range(0, 255)); rx_src.push_back($urandom_range(0, 255));
        end
    endtask

    task automatic start_txn(bit rd, logic [6:0] dev, logic [7:0] rg, logic [3:0] len, int nk, int junk);
        ev_log.delete(); rx_got.delete(); tx_q = tx_src;
        nack_idx = nk; wr_cnt = 0; rd_cnt = 0; txr_cnt = 0; done_cnt = 0; busy_drop = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_read = rd; cmd_dev = dev; cmd_reg = rg; cmd_len = len;
        @(negedge clk);
        in_txn = 1;
        for (int i = 0; i < junk; i++) begin
            cmd_read = ~rd; cmd_dev = 7'($urandom); cmd_reg = 8'($urandom); cmd_len = 4'($urandom);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (done_cnt > 0) ok = 1;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #3;
        total++;
        if ({busy, done, err_nack, err_timeout, tx_ready, rx_valid, rx_data, phy_start_req,
             phy_stop_req, phy_write_req, phy_read_req, phy_master_ack, phy_data_out} !== 27'd0) begin
            bad++; $display("FAIL reset_outputs: busy=%b done=%b data_out=%h rx_data=%h, all must be 0",
                            busy, done, phy_data_out, rx_data);
        end
        @(negedge clk); rst_n = 1'b1;
        $display("test_reset: outputs checked in reset");
    endtask

    task automatic test_write_basic();
        bit ok; int d;
        tx_src.delete(); tx_src.push_back(32'hA5);
        build_model(0, 7'h50, 8'h10, 0, -1);
        start_txn(0, 7'h50, 8'h10, 4'd0, -1, 8);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL wr_basic_done: got no done, want done"); end
        d = first_diff(ev_log, exp_q);
        total++; if (d != -1) begin bad++; $display("FAIL wr_basic_events: at %0d got %h want %h", d,
            (d < ev_log.size()) ? ev_log[d] : -1, (d < exp_q.size()) ? exp_q[d] : -1); end
        total++; if (txr_cnt != 1) begin bad++; $display("FAIL wr_basic_tx_ready: got %0d want 1", txr_cnt); end
        total++; if ({done_nack, done_to} !== 2'b00) begin bad++;
            $display("FAIL wr_basic_errs: got nack=%b to=%b want 0 0", done_nack, done_to); end
        total++; if (busy_drop != 0 || done_busy != 0 || done_cnt != 1) begin bad++;
            $display("FAIL wr_basic_busy: drops=%0d busy_at_done=%b dones=%0d want 0 0 1",
                     busy_drop, done_busy, done_cnt); end
        $display("test_write_basic: events=%0d tx_ready=%0d", ev_log.size(), txr_cnt);
    endtask

    task automatic test_read_basic();
        bit ok; int d;
        rx_src.delete(); rx_src.push_back(32'h11); rx_src.push_back(32'h22); rx_src.push_back(32'h33);
        tx_src.delete();
        build_model(1, 7'h50, 8'h20, 2, -1);
        start_txn(1, 7'h50, 8'h20, 4'd2, -1, 5);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL rd_basic_done: got no done, want done"); end
        d = first_diff(ev_log, exp_q);
        total++; if (d != -1) begin bad++; $display("FAIL rd_basic_events: at %0d got %h want %h", d,
            (d < ev_log.size()) ? ev_log[d] : -1, (d < exp_q.size()) ? exp_q[d] : -1); end
        d = first_diff(rx_got, exp_rx);
        total++; if (d != -1) begin bad++; $display("FAIL rd_basic_rx: at %0d got %h want %h", d,
            (d < rx_got.size()) ? rx_got[d] : -1, (d < exp_rx.size()) ? exp_rx[d] : -1); end
        total++; if ({done_nack, done_to, busy_drop != 0, txr_cnt != 0} !== 4'b0) begin bad++;
            $display("FAIL rd_basic_flags: nack=%b to=%b drops=%0d tx_ready=%0d want all 0",
                     done_nack, done_to, busy_drop, txr_cnt); end
        $display("test_read_basic: rx bytes=%0d", rx_got.size());
    endtask

    task automatic test_nack(string name, bit rd, int len, int nk);
        bit ok; int d;
        fill_random();
        build_model(rd, 7'($urandom), 8'($urandom), len, nk);
        start_txn(rd, exp_q[1][7:1], exp_q[2][7:0], 4'(len), nk, 0);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL %s_done: got no done, want done", name); end
        d = first_diff(ev_log, exp_q);
        total++; if (d != -1) begin bad++; $display("FAIL %s_events: at %0d got %h want %h", name, d,
            (d < ev_log.size()) ? ev_log[d] : -1, (d < exp_q.size()) ? exp_q[d] : -1); end
        total++; if (txr_cnt != exp_txr) begin bad++;
            $display("FAIL %s_tx_ready: got %0d want %0d", name, txr_cnt, exp_txr); end
        total++; if (done_nack !== exp_nack || done_to !== 1'b0) begin bad++;
            $display("FAIL %s_errs: got nack=%b to=%b want %b 0", name, done_nack, done_to, exp_nack); end
        d = first_diff(rx_got, exp_rx);
        total++; if (d != -1) begin bad++; $display("FAIL %s_rx: got %0d bytes want %0d", name,
            rx_got.size(), exp_rx.size()); end
        $display("%s: rd=%0d len=%0d nack_at=%0d events=%0d", name, rd, len, nk, ev_log.size());
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 6; n++) begin
            bit rd = 1'($urandom_range(0, 1));
            int len = $urandom_range(0, 15);
            r = $urandom_range(0, 5);
            test_nack("random", rd, len, (r < 3) ? -1 : $urandom_range(0, rd ? 2 : len + 2));
        end
    endtask

    task automatic test_timeout();
        bit ok;
        fill_random();
        phy_mute = 1;
        start_txn(0, 7'h33, 8'h44, 4'd1, -1, 0);
        wait_done(ok);
        phy_mute = 0;
        total++; if (!ok) begin bad++; $display("FAIL timeout_done: got no done, want done"); end
        total++; if (done_cyc - req_cyc != TO + 1) begin bad++;
            $display("FAIL timeout_latency: got %0d cycles want %0d", done_cyc - req_cyc, TO + 1); end
        total++; if (ev_log.size() != 1 || ev_log[0] != EV_START) begin bad++;
            $display("FAIL timeout_events: got %0d events want only start", ev_log.size()); end
        total++; if ({done_to, done_nack, busy} !== 3'b100) begin bad++;
            $display("FAIL timeout_flags: got to=%b nack=%b busy=%b want 1 0 0", done_to, done_nack, busy); end
        $display("test_timeout: done after %0d cycles", done_cyc - req_cyc);
    endtask

    task automatic test_reset_mid_read();
        bit seen = 0;
        fill_random();
        start_txn(1, 7'h2A, 8'h05, 4'd3, -1, 0);
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            foreach (ev_log[k]) if (ev_log[k] == (EV_RD | 1)) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL rst_mid_reach_rdata: got no read, want read"); end
        @(negedge clk); #3;
        in_txn = 0; rst_n = 1'b0; #1;
        total++;
        if ({busy, done, err_nack, err_timeout, tx_ready, rx_valid, rx_data, phy_start_req,
             phy_stop_req, phy_write_req, phy_read_req, phy_master_ack, phy_data_out} !== 27'd0) begin
            bad++; $display("FAIL rst_mid_outputs: busy=%b master_ack=%b data_out=%h rx_data=%h, all must be 0",
                            busy, phy_master_ack, phy_data_out, rx_data);
        end
        @(negedge clk); rst_n = 1'b1; ev_log.delete();
        repeat (10) @(negedge clk);
        total++; if (ev_log.size() != 0 || busy !== 1'b0) begin bad++;
            $display("FAIL rst_mid_idle: got %0d events busy=%b want 0 0", ev_log.size(), busy); end
        $display("test_reset_mid_read: reset applied during read data");
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_nack("addr_nack", 0, 0, 0);
        test_nack("data_nack", 0, 3, 3);
        test_nack("addr_r_nack", 1, 4, 2);
        test_random();
        test_timeout();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
